pe_link_retimer: RTL
====================

// Module: pe_link_retimer
// PURPOSE
//  Elastic retiming stage on one inter-PE link channel. It sits between a neighbouring PE's
//  output port (O_FTk/I_BTk) and this PE's input port (I_FTk/O_BTk).
//  Breaks the combinational FTk/BTk path with a small token FIFO and tracks path
//  acquire/release so a link channel is owned by one stream at a time.
// PARAMETERS
//  WIDTH_DATA    32  data field width of forward token
//  DEPTH_FIFO     4  token FIFO entries (power of two, >=2)
//  WIDTH_LENGTH  10  width of per-path token counter
// PORTS
//  clock       in   1               system clock
//  reset       in   1               asynchronous, active-low reset
//  I_FTk       in   FTk_t           upstream forward token {v,a,r,c,d[WIDTH_DATA]}
//  O_BTk       out  BTk_t           backward token to upstream {n,t,v,c}
//  O_FTk       out  FTk_t           forward token to downstream
//  I_BTk       in   BTk_t           backward token from downstream
//  O_Busy      out  1               path acquired (state != IDLE)
//  O_Length    out  WIDTH_LENGTH    tokens forwarded on current path
// BEHAVIOUR
//  - Reset: FIFO empty, rd/wr ptrs 0, state IDLE, O_FTk='0, O_BTk='0, O_Busy=0, O_Length=0.
//  - Push: I_FTk.v & ~O_BTk.n. O_BTk.n = full | (state==DRAIN). Registered, so n rises the cycle after
//    the push that fills the FIFO. Pushing while n=1 is a protocol error. Data is dropped, not stored.
//  - Pop: FIFO non-empty & ~I_BTk.n. O_FTk is driven from FIFO head register. O_FTk.v=0 when empty.
//  - Latency: 1 cycle push-to-O_FTk.v when empty and no stall. Throughput 1 token/cycle steady-state.
//  - Push and pop in the same cycle: allowed in any fill level including full (count unchanged).
//  - Pointer wrap: modulo DEPTH_FIFO. Full/empty are distinguished by an extra MSB on the pointers.
//  - FSM (advances on pushed token flags):
//     IDLE  : push with a=1 -> ACQ. Push with a=0 is accepted and forwarded, with no state change.
//     ACQ   : push with r=1 -> DRAIN. O_Length +1 per pop while in ACQ or DRAIN.
//     DRAIN : no new pushes. When FIFO is empty and the last pop has occurred -> IDLE, and O_Length clears the next cycle.
//     A token with a=1 and r=1 together in IDLE goes directly to DRAIN.
//  - O_Length saturates at 2^WIDTH_LENGTH-1 (no wrap).
//  - BTk return: O_BTk.{t,v,c} = I_BTk.{t,v,c} registered 1 cycle. O_BTk.n is as above.
//    I_BTk.t in ACQ forces DRAIN (downstream terminate). Tokens already queued are still delivered.
//  - Reset mid-operation: asynchronous clear; queued tokens are discarded; the path is released.
// CONFIGURATION
//  PE_LINK_RETIMER_BYPASS_EN: when defined, empty FIFO plus ~I_BTk.n gives combinational
//   I_FTk->O_FTk cut-through (0-cycle latency), and the token is not written.
//   In that mode the FSM and O_Length still update on the bypassed token.
//   Undefined: always registered, 1-cycle minimum latency.
// STRUCTURE
//  - pkg_en: FTk_t, BTk_t, and the retimer FSM enum (state_ret_t: IDLE, ACQ, DRAIN).
//  - One sub-module: pe_token_fifo (DEPTH_FIFO x FTk_t, push/pop/full/empty/head).
//  - Top holds the FSM, the length counter and the BTk return register.
// TESTING
//  1 Single token {v=1,a=1,r=1,d=32'h5A} into empty -> O_FTk.d=5A next cycle; O_Busy 1->0; O_Length reads 1 before clear.
//  2 Stream of 8 tokens with I_BTk.n=1 held -> 4 stored, O_BTk.n=1 after 4th; release n -> 8 delivered in order.
//  3 Simultaneous push/pop at full for 20 cycles -> count stays 4, no loss, ptrs wrap 5 times.
//  4 a=1 then 3 tokens then r=1 -> states IDLE->ACQ->DRAIN->IDLE; O_BTk.n=1 during DRAIN; O_Length=5.
//  5 I_BTk.t=1 mid-ACQ with 2 queued -> both delivered, DRAIN->IDLE, new pushes blocked until IDLE.
//  6 Assert reset with 3 queued -> O_FTk.v=0 immediately; after release: state IDLE, empty; BYPASS_EN build: 0-cycle pass-through.

Source files
------------

// File: rtl/pe_link_retimer_pkg.sv
// Shared types for the inter-PE link retimer: forward/backward token layouts and
// the path-ownership FSM encoding.
package pe_link_retimer_pkg;

    localparam int WIDTH_DATA = 32;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        DRAIN = 2'd2
    } state_ret_t;

endpackage

// File: rtl/pe_token_fifo.sv
// Small forward-token FIFO with extended pointers (extra MSB separates full from empty).
// The head entry is presented combinationally and forced to zero when empty.
module pe_token_fifo
    import pe_link_retimer_pkg::*;
#(
    parameter int DEPTH_FIFO = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  FTk_t                        push_data,
    input  logic                        pop,
    output FTk_t                        head,
    output logic                        empty,
    output logic [$clog2(DEPTH_FIFO):0] count_next
);

    localparam int AW = $clog2(DEPTH_FIFO);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full;
    logic        wr_en;
    logic        rd_en;
    FTk_t        mem_q [DEPTH_FIFO];

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        // A push into a full FIFO is only safe when the head leaves in the same cycle.
        rd_en = pop & ~empty;
        wr_en = push & (~full | rd_en);

        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_en};
        count_next = wr_ptr_d - rd_ptr_d;

        head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pe_link_retimer.sv
// Elastic retiming stage on one inter-PE link channel with path acquire/release tracking.
// Optional PE_LINK_RETIMER_BYPASS_EN: zero-latency cut-through when the FIFO is empty.
module pe_link_retimer
    import pe_link_retimer_pkg::*;
#(
    parameter int DEPTH_FIFO   = 4,
    parameter int WIDTH_LENGTH = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output FTk_t                    O_FTk,
    input  BTk_t                    I_BTk,
    output logic                    O_Busy,
    output logic [WIDTH_LENGTH-1:0] O_Length
);

    localparam int AW = $clog2(DEPTH_FIFO);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH_FIFO);

    state_ret_t              state_q, state_d;
    BTk_t                    btk_q, btk_d;
    logic                    busy_q, busy_d;
    logic [WIDTH_LENGTH-1:0] length_q, length_d;
    logic [WIDTH_LENGTH-1:0] length_base;

    logic                    push;
    logic                    bypass;
    logic                    fifo_push;
    logic                    taken;
    logic                    count_en;
    FTk_t                    fifo_head;
    logic                    fifo_empty;
    logic [AW:0]             fifo_count_next;

    pe_token_fifo #(
        .DEPTH_FIFO (DEPTH_FIFO)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (I_FTk),
        .pop        (~I_BTk.n),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count_next (fifo_count_next)
    );

    always_comb begin
        push = I_FTk.v & ~btk_q.n;
`ifdef PE_LINK_RETIMER_BYPASS_EN
        // Reset gates the cut-through so nothing leaks downstream while held in reset.
        bypass = fifo_empty & ~I_BTk.n & reset;
`else
        bypass = 1'b0;
`endif
        fifo_push = push & ~bypass;
        taken     = (~fifo_empty & ~I_BTk.n) | (bypass & push);

        O_FTk = fifo_head;
`ifdef PE_LINK_RETIMER_BYPASS_EN
        if (bypass) begin
            O_FTk = push ? I_FTk : '0;
        end
`endif

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push && I_FTk.a) begin
                    state_d = I_FTk.r ? DRAIN : ACQ;
                end
            end
            ACQ: begin
                if ((push && I_FTk.r) || I_BTk.t) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count_next == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Length restarts from zero on the first cycle of IDLE; a bypassed
        // acquiring token is counted against the path it opens.
        count_en    = taken & ((state_q != IDLE) | (bypass & push & I_FTk.a));
        length_base = (state_q == IDLE) ? '0 : length_q;
        length_d    = length_base;
        if (count_en && (length_base != {WIDTH_LENGTH{1'b1}})) begin
            length_d = length_base + WIDTH_LENGTH'(1);
        end

        busy_d  = (state_d != IDLE);
        btk_d.n = (fifo_count_next == FULL_COUNT) | (state_d == DRAIN);
        btk_d.t = I_BTk.t;
        btk_d.v = I_BTk.v;
        btk_d.c = I_BTk.c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            btk_q    <= '0;
            busy_q   <= 1'b0;
            length_q <= '0;
        end else begin
            state_q  <= state_d;
            btk_q    <= btk_d;
            busy_q   <= busy_d;
            length_q <= length_d;
        end
    end

    assign O_BTk    = btk_q;
    assign O_Busy   = busy_q;
    assign O_Length = length_q;

endmodule
